// File: rtl/mult_frame_ctrl.sv
// Frame controller: assembles 9-byte UART command frames (A, B, opcode), runs one multiply and
// streams the 64-bit product back. Define MULT_FRAME_CHECKSUM_EN to append an XOR checksum byte.
module mult_frame_ctrl #(
    parameter int unsigned BYTE_TIMEOUT = 4320,
    parameter int unsigned MULT_TIMEOUT = 1024
) (
    input  logic        CLK_IN,
    input  logic        resetIn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic        mult_signed,
    output logic        mult_start,
    input  logic        mult_done,
    input  logic [63:0] mult_result,
    output logic        RECEIVED_OUT,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam int unsigned TimerMax = (BYTE_TIMEOUT > MULT_TIMEOUT) ? BYTE_TIMEOUT : MULT_TIMEOUT;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StDecode,
        StLaunch,
        StWait,
        StSend,
`ifdef MULT_FRAME_CHECKSUM_EN
        StChk,
`endif
        StErrSend
    } state_e;

    state_e            state_q, state_d;
    logic [71:0]       frame_q, frame_d;
    logic [3:0]        count_q, count_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [63:0]       result_q, result_d;
    logic [2:0]        idx_q, idx_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic              signed_q, signed_d;
    logic              received_q, received_d;
    logic              err_q, err_d;
    logic              overrun_q, overrun_d;
    logic              start_q, start_d;
    logic              tx_hold_q;
    logic              tx_ready;
    logic              tx_go;
    logic [7:0]        tx_byte;

`ifdef MULT_FRAME_CHECKSUM_EN
    logic [7:0] csum;
    always_comb begin
        csum = 8'h00;
        for (int i = 0; i < 8; i++) csum = csum ^ result_q[i*8 +: 8];
    end
`endif

    // The transmitter raises tx_busy one cycle late, so the cycle after an issue is blind.
    assign tx_ready = !tx_hold_q && !tx_busy;

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        count_d    = count_q;
        timer_d    = timer_q;
        result_d   = result_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        signed_d   = signed_q;
        received_d = 1'b0;
        err_d      = 1'b0;
        start_d    = 1'b0;
        tx_go      = 1'b0;
        tx_byte    = 8'h00;
        overrun_d  = rx_valid && (state_q != StIdle) && (state_q != StCollect);

        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (rx_valid) begin
                    frame_d[7:0] = rx_data;
                    count_d      = 4'd1;
                    state_d      = StCollect;
                end
            end
            StCollect: begin
                if (rx_valid) begin
                    frame_d[{count_q, 3'b000} +: 8] = rx_data;
                    count_d = count_q + 4'd1;
                    timer_d = '0;
                    if (count_q == 4'd8) begin
                        received_d = 1'b1;
                        state_d    = StDecode;
                    end
                end else if (timer_q == TimerW'(BYTE_TIMEOUT)) begin
                    err_d   = 1'b1;
                    count_d = 4'd0;
                    timer_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StDecode: begin
                count_d = 4'd0;
                idx_d   = 3'd0;
                if (frame_q[71:65] == 7'd0) begin
                    a_d      = frame_q[31:0];
                    b_d      = frame_q[63:32];
                    signed_d = frame_q[64];
                    start_d  = 1'b1;
                    state_d  = StLaunch;
                end else begin
                    err_d   = 1'b1;
                    state_d = StErrSend;
                end
            end
            StLaunch: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (mult_done) begin
                    result_d = mult_result;
                    idx_d    = 3'd0;
                    state_d  = StSend;
                end else if (timer_q == TimerW'(MULT_TIMEOUT)) begin
                    err_d   = 1'b1;
                    idx_d   = 3'd0;
                    state_d = StErrSend;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StSend: begin
                tx_byte = result_q[{idx_q, 3'b000} +: 8];
                if (tx_ready) begin
                    tx_go = 1'b1;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef MULT_FRAME_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StIdle;
`endif
                    end
                end
            end
`ifdef MULT_FRAME_CHECKSUM_EN
            StChk: begin
                tx_byte = csum;
                if (tx_ready) begin
                    tx_go   = 1'b1;
                    state_d = StIdle;
                end
            end
`endif
            StErrSend: begin
                tx_byte = 8'hEE;
                if (tx_ready) begin
                    tx_go = 1'b1;
`ifdef MULT_FRAME_CHECKSUM_EN
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd1) state_d = StIdle;
`else
                    state_d = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge resetIn) begin
        if (!resetIn) begin
            state_q    <= StIdle;
            frame_q    <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            result_q   <= '0;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            signed_q   <= 1'b0;
            received_q <= 1'b0;
            err_q      <= 1'b0;
            overrun_q  <= 1'b0;
            start_q    <= 1'b0;
            tx_hold_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            result_q   <= result_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            signed_q   <= signed_d;
            received_q <= received_d;
            err_q      <= err_d;
            overrun_q  <= overrun_d;
            start_q    <= start_d;
            tx_hold_q  <= tx_go;
        end
    end

    assign tx_start     = tx_go;
    assign tx_data      = tx_go ? tx_byte : 8'h00;
    assign mult_a       = a_q;
    assign mult_b       = b_q;
    assign mult_signed  = signed_q;
    assign mult_start   = start_q;
    assign RECEIVED_OUT = received_q;
    assign frame_err    = err_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mult_frame_ctrl.sv
// Self-checking bench for mult_frame_ctrl: randomized frames against an arithmetic reference model,
// with behavioural UART transmitter and multiplier models.
module tb_mult_frame_ctrl;

    logic        CLK_IN;
    logic        resetIn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic        mult_signed;
    logic        mult_start;
    logic        mult_done;
    logic [63:0] mult_result;
    logic        RECEIVED_OUT;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    mult_frame_ctrl dut (
        .CLK_IN       (CLK_IN),
        .resetIn      (resetIn),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_signed  (mult_signed),
        .mult_start   (mult_start),
        .mult_done    (mult_done),
        .mult_result  (mult_result),
        .RECEIVED_OUT (RECEIVED_OUT),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .busy         (busy)
    );

    int checks, errors;
    int cyc;
    int recv_cnt, err_cnt, start_cnt, ovr_cnt, tx_viol;
    int recv_cyc, start_cyc, last_rx_cyc, mult_due, fired;
    int tx_issued, tx_served, busy_left;
    int unsigned mult_lat, tx_len;
    logic [31:0] cap_a, cap_b;
    logic        cap_s;
    logic [7:0]  tx_q[$];
    logic [7:0]  exp_q[$];
    int s_recv, s_err, s_start, s_ovr, s_viol;

    initial CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;
    always @(posedge CLK_IN) cyc <= cyc + 1;

    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                                input logic s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Observers run on the falling edge, away from the DUT's active edge.
    always @(negedge CLK_IN) begin
        if (RECEIVED_OUT) begin recv_cnt++; recv_cyc = cyc; end
        if (frame_err) err_cnt++;
        if (overrun) ovr_cnt++;
        if (mult_start) begin
            start_cnt++;
            start_cyc = cyc;
            cap_a = mult_a;
            cap_b = mult_b;
            cap_s = mult_signed;
            mult_due = cyc + int'(mult_lat);
        end
        if (tx_start) begin
            if (tx_busy !== 1'b0) tx_viol++;
            tx_q.push_back(tx_data);
            tx_issued++;
        end
    end

    // Transmitter: busy rises the cycle after tx_start and stays up for tx_len cycles.
    always @(posedge CLK_IN) begin
        #1;
        if (tx_served != tx_issued) begin
            tx_served = tx_issued;
            busy_left = int'(tx_len);
        end else if (busy_left != 0) begin
            busy_left--;
        end
        tx_busy = (busy_left != 0);
    end

    // Multiplier: answers mult_lat cycles after mult_start (0 = never answers).
    always @(posedge CLK_IN) begin
        #1;
        mult_done   = 1'b0;
        mult_result = {$urandom(), $urandom()};
        if (mult_lat != 0 && fired != start_cnt && cyc == mult_due) begin
            mult_done   = 1'b1;
            mult_result = ref_product(cap_a, cap_b, cap_s);
            fired       = start_cnt;
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic snap();
        s_recv = recv_cnt; s_err = err_cnt; s_start = start_cnt; s_ovr = ovr_cnt;
        s_viol = tx_viol;
        tx_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK_IN); #1;
        rx_data = b; rx_valid = 1'b1; last_rx_cyc = cyc;
        @(posedge CLK_IN); #1;
        rx_valid = 1'b0; rx_data = 8'($urandom());
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                              input int lo, input int hi, input int maxgap);
        logic [71:0] f;
        f = {op, b, a};
        for (int i = lo; i <= hi; i++) begin
            send_byte(f[i*8 +: 8]);
            if (i < hi) repeat ($urandom_range(0, maxgap)) @(posedge CLK_IN);
        end
    endtask

    task automatic build_expected(input logic [31:0] a, input logic [31:0] b,
                                  input logic [7:0] op, input bit resp_err);
        logic [63:0] p;
        logic [7:0] x;
        exp_q.delete();
        if (resp_err || op > 8'h01) begin
            exp_q.push_back(8'hEE);
`ifdef MULT_FRAME_CHECKSUM_EN
            exp_q.push_back(8'hEE);
`endif
        end else begin
            p = ref_product(a, b, op[0]);
            x = 8'h00;
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back(p[i*8 +: 8]);
                x = x ^ p[i*8 +: 8];
            end
`ifdef MULT_FRAME_CHECKSUM_EN
            exp_q.push_back(x);
`endif
        end
    endtask

    task automatic check_frame(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [7:0] op, input bit resp_err, input int exp_err,
                               input int exp_ovr, input bit timed);
        bit good_op;
        int n;
        good_op = (op <= 8'h01);
        n = 0;
        while (busy !== 1'b0 && n < 20000) begin @(posedge CLK_IN); #1; n++; end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s completion: busy=%b, required 0", name, busy);
        end
        build_expected(a, b, op, resp_err);
        checks++;
        if (tx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s tx_count: got %0d bytes, required %0d", name, tx_q.size(),
                     exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (tx_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s tx_byte[%0d]: got %h, required %h", name, i, tx_q[i],
                             exp_q[i]);
                end
            end
        end
        checks++;
        if (recv_cnt - s_recv != 1) begin
            errors++; $display("FAIL %s received: %0d pulses, required 1", name, recv_cnt - s_recv);
        end
        checks++;
        if (start_cnt - s_start != int'(good_op)) begin
            errors++;
            $display("FAIL %s mult_start: %0d pulses, required %0d", name, start_cnt - s_start,
                     int'(good_op));
        end
        checks++;
        if (err_cnt - s_err != exp_err) begin
            errors++;
            $display("FAIL %s frame_err: %0d pulses, required %0d", name, err_cnt - s_err, exp_err);
        end
        checks++;
        if (ovr_cnt - s_ovr != exp_ovr) begin
            errors++;
            $display("FAIL %s overrun: %0d pulses, required %0d", name, ovr_cnt - s_ovr, exp_ovr);
        end
        checks++;
        if (tx_viol != s_viol) begin
            errors++;
            $display("FAIL %s tx_start_while_busy: %0d events, required 0", name, tx_viol - s_viol);
        end
        if (good_op) begin
            checks++;
            if ({cap_a, cap_b, cap_s} !== {a, b, op[0]}) begin
                errors++;
                $display("FAIL %s operands: got a=%h b=%h s=%b, required a=%h b=%h s=%b", name,
                         cap_a, cap_b, cap_s, a, b, op[0]);
            end
        end
        if (timed) begin
            checks++;
            if (recv_cyc != last_rx_cyc + 1) begin
                errors++;
                $display("FAIL %s received_timing: cycle %0d, required %0d", name, recv_cyc,
                         last_rx_cyc + 1);
            end
            if (good_op) begin
                checks++;
                if (start_cyc != last_rx_cyc + 2) begin
                    errors++;
                    $display("FAIL %s start_timing: cycle %0d, required %0d", name, start_cyc,
                             last_rx_cyc + 2);
                end
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({tx_data, tx_start, mult_a, mult_b, mult_signed, mult_start, RECEIVED_OUT, frame_err,
             overrun, busy} !== 79'd0) begin
            errors++;
            $display("FAIL %s outputs: tx=%h/%b a=%h b=%h s=%b st=%b rcv=%b err=%b ovr=%b busy=%b, required all 0",
                     name, tx_data, tx_start, mult_a, mult_b, mult_signed, mult_start,
                     RECEIVED_OUT, frame_err, overrun, busy);
        end
    endtask

    task automatic test_reset();
        resetIn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        mult_lat = 5; tx_len = 3;
        repeat (3) @(posedge CLK_IN);
        #2;
        check_outputs_zero("reset_held");
        resetIn = 1'b1;
        repeat (2) @(posedge CLK_IN);
        #1;
        check_outputs_zero("reset_released");
    endtask

    task automatic test_basic();
        snap(); mult_lat = 5; tx_len = 3;
        send_frame(32'd3, 32'd5, 8'h00, 0, 8, 0);
        check_frame("basic", 32'd3, 32'd5, 8'h00, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_signed();
        snap(); mult_lat = 7; tx_len = 2;
        send_frame(32'hFFFF_FFFF, 32'd2, 8'h01, 0, 8, 2);
        check_frame("signed", 32'hFFFF_FFFF, 32'd2, 8'h01, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_bad_opcode();
        snap(); mult_lat = 5;
        send_frame(32'h1234_5678, 32'h9ABC_DEF0, 8'h03, 0, 8, 1);
        check_frame("bad_opcode", 32'h1234_5678, 32'h9ABC_DEF0, 8'h03, 1'b1, 1, 0, 1'b1);
    endtask

    task automatic test_byte_timeout();
        logic [31:0] a, b;
        a = $urandom(); b = $urandom();
        snap(); mult_lat = 4;
        send_frame(32'hDEAD_BEEF, 32'h0BAD_F00D, 8'h00, 0, 3, 0);
        repeat (4320) @(posedge CLK_IN);  // 4321 idle cycles before the next byte
        send_frame(a, b, 8'h00, 0, 8, 1);
        check_frame("byte_timeout", a, b, 8'h00, 1'b0, 1, 0, 1'b1);
    endtask

    task automatic test_timeout_edge();
        logic [31:0] a, b;
        a = $urandom(); b = $urandom();
        snap(); mult_lat = 6;
        send_frame(a, b, 8'h01, 0, 3, 0);
        repeat (4319) @(posedge CLK_IN);  // next byte lands exactly in the expiry cycle
        send_frame(a, b, 8'h01, 4, 8, 0);
        check_frame("timeout_edge", a, b, 8'h01, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_mult_timeout();
        snap(); mult_lat = 1026;
        send_frame(32'd7, 32'd9, 8'h00, 0, 8, 0);
        check_frame("mult_timeout", 32'd7, 32'd9, 8'h00, 1'b1, 1, 0, 1'b1);
    endtask

    task automatic test_done_wins();
        snap(); mult_lat = 1025;
        send_frame(32'd11, 32'hFFFF_FFF0, 8'h01, 0, 8, 0);
        check_frame("done_at_expiry", 32'd11, 32'hFFFF_FFF0, 8'h01, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_overrun();
        logic [31:0] a, b;
        int n;
        a = $urandom(); b = $urandom();
        snap(); mult_lat = 30; tx_len = 2;
        send_frame(a, b, 8'h00, 0, 8, 1);
        n = 0;
        while (start_cnt == s_start && n < 100) begin @(posedge CLK_IN); #1; n++; end
        repeat (3) @(posedge CLK_IN);
        send_byte(8'h5A);
        check_frame("overrun", a, b, 8'h00, 1'b0, 0, 1, 1'b0);
    endtask

    task automatic test_reset_in_send();
        logic [31:0] a, b;
        int n;
        snap(); mult_lat = 3; tx_len = 12;
        send_frame(32'hCAFE_0001, 32'h0000_0100, 8'h00, 0, 8, 0);
        n = 0;
        while (tx_q.size() < 3 && n < 2000) begin @(posedge CLK_IN); #1; n++; end
        checks++;
        if (tx_q.size() != 3) begin
            errors++; $display("FAIL reset_send reach_byte3: %0d bytes sent, required 3", tx_q.size());
        end
        @(posedge CLK_IN); #4;
        resetIn = 1'b0;
        #1;
        check_outputs_zero("reset_in_send");
        repeat (3) @(posedge CLK_IN);
        #4;
        resetIn = 1'b1;
        a = $urandom(); b = $urandom();
        snap(); tx_len = 2; mult_lat = 4;
        send_frame(a, b, 8'h01, 0, 8, 1);
        check_frame("after_reset", a, b, 8'h01, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [7:0] op;
        int unsigned r;
        for (int k = 0; k < 20; k++) begin
            a = $urandom(); b = $urandom();
            r = $urandom_range(0, 4);
            op = (r == 0) ? 8'h00 : (r == 1) ? 8'h01 : 8'($urandom());
            mult_lat = $urandom_range(1, 40);
            tx_len = $urandom_range(1, 8);
            snap();
            send_frame(a, b, op, 0, 8, 3);
            check_frame("random", a, b, op, 1'b0, int'(op > 8'h01), 0, 1'b1);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        test_reset();
        test_basic();
        test_signed();
        test_bad_opcode();
        test_byte_timeout();
        test_timeout_edge();
        test_mult_timeout();
        test_done_wins();
        test_overrun();
        test_reset_in_send();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_frame_ctrl.md
# mult_frame_ctrl

Frame controller that sequences the shared multiplier from the UART byte stream. It assembles 9 received octets into a command frame: A, B, then opcode, each least-significant byte first. It launches one multiply, waits for completion, and serializes the 64-bit product back to the UART transmitter. It sits between the UART receiver/transmitter and the multiplier datapath inside `multiplier_top`, and drives the `RECEIVED_OUT` frame-acknowledge line.

## Interface
- `BYTE_TIMEOUT`, default 4320: idle clocks allowed between bytes of a frame (10 bit-times at 432 clocks/bit).
- `MULT_TIMEOUT`, default 1024: clocks allowed from `mult_start` to `mult_done`.
- `CLK_IN` in 1: single clock, all logic on its rising edge.
- `resetIn` in 1: reset, asynchronous and active-low.
- `rx_data` in 8: received byte, valid when `rx_valid` is high.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `tx_data` out 8: byte to transmit, valid with `tx_start`.
- `tx_start` out 1: one-cycle transmit request.
- `tx_busy` in 1: transmitter busy.
- `mult_a` out 32: operand A, frame bits [31:0].
- `mult_b` out 32: operand B, frame bits [63:32].
- `mult_signed` out 1: 1 for a signed multiply.
- `mult_start` out 1: one-cycle launch pulse.
- `mult_done` in 1: one-cycle completion strobe.
- `mult_result` in 64: product, valid with `mult_done`.
- `RECEIVED_OUT` out 1: one-cycle pulse when the 9th byte is accepted.
- `frame_err` out 1: one-cycle pulse on timeout or bad opcode.
- `overrun` out 1: one-cycle pulse when a byte is dropped.
- `busy` out 1: high in every state except IDLE.

## Operation
- Reset: all outputs 0, state IDLE, byte count 0, timers 0.
- States and transitions:
  - IDLE: on `rx_valid`, store the byte in frame[7:0], set count=1, go to COLLECT.
  - COLLECT: each `rx_valid` stores the byte at frame[count*8 +: 8] and increments count.
    - On accepting the byte that makes count=9, pulse `RECEIVED_OUT` and go to DECODE.
    - If the inter-byte timer reaches `BYTE_TIMEOUT`, discard the partial frame, pulse `frame_err`, go to IDLE.
  - DECODE: opcode = frame[71:64].
    - 0x00: unsigned multiply, go to LAUNCH.
    - 0x01: signed multiply, go to LAUNCH.
    - Any other value: pulse `frame_err`, go to ERR_SEND.
  - LAUNCH: drive `mult_a`/`mult_b`/`mult_signed` from the frame, pulse `mult_start`, go to WAIT.
  - WAIT: on `mult_done`, latch `mult_result` and go to SEND.
    - If the timer reaches `MULT_TIMEOUT`, pulse `frame_err` and go to ERR_SEND.
  - SEND: transmit result bytes 0..7, LSB first, then go to IDLE (or CHK, see Configuration).
  - ERR_SEND: transmit the single byte 0xEE, then go to IDLE.
- Operands hold stable from LAUNCH until leaving WAIT.
- `rx_valid` in DECODE/LAUNCH/WAIT/SEND/ERR_SEND: the byte is dropped and `overrun` is pulsed. Dropped bytes are never buffered.

## Timing
- `RECEIVED_OUT` asserts in the cycle after the 9th `rx_valid`.
- DECODE takes 1 cycle.
- `mult_start` asserts 2 cycles after the 9th `rx_valid`.
- Each transmit issue takes two conditions:
  - `tx_start` is pulsed only in a cycle where `tx_busy` is 0.
  - In the cycle after `tx_start`, `tx_busy` is ignored, since the transmitter raises it one cycle late.
  - After that, the controller waits for `tx_busy` to be 0 before the next `tx_start`.
- The first `tx_start` occurs no earlier than 1 cycle after `mult_done`.
- Inter-byte timer:
  - Cleared on every accepted byte.
  - An `rx_valid` in the expiry cycle wins: the byte is accepted and no error is raised.
- `mult_done` in the same cycle as the `MULT_TIMEOUT` expiry: done wins.
- `mult_done` outside WAIT is ignored.
- `resetIn` low at any point aborts the current frame asynchronously and returns to the reset values. A transmit or multiply already in progress is abandoned.

## Configuration
- `MULT_FRAME_CHECKSUM_EN` defined:
  - After result byte 7, add state CHK, which transmits a 9th byte equal to the XOR of the 8 result bytes.
  - ERR_SEND transmits 0xEE followed by 0xEE.
- `MULT_FRAME_CHECKSUM_EN` undefined:
  - Exactly 8 result bytes are sent.
  - ERR_SEND sends exactly one 0xEE.
  - No CHK state or XOR logic is present.

## Test plan
- Frame 03 00 00 00 05 00 00 00 00, multiplier model returns 15 after 5 cycles:
  - `RECEIVED_OUT` pulses once.
  - `mult_a`=3, `mult_b`=5, `mult_signed`=0.
  - TX bytes are 0F 00 00 00 00 00 00 00, plus checksum 0F if the macro is defined.
- Frame with A=0xFFFFFFFF, B=2, opcode 0x01, model returns 64'hFFFFFFFFFFFFFFFE:
  - `mult_signed`=1.
  - TX bytes are FE FF FF FF FF FF FF FF.
- Opcode 0x03: `frame_err` pulses, `mult_start` never asserts, TX sends 0xEE.
- 4 bytes, then a gap of 4321 cycles, then a full valid frame:
  - `frame_err` pulses once after the gap.
  - The second frame decodes correctly from byte 0.
- Byte injected during WAIT: `overrun` pulses and the result is unaffected.
- `resetIn` pulled low during SEND byte 3: all outputs return to 0, and a fresh frame afterwards completes normally.
